// File: rtl/message_schedule_pkg.sv
// message_schedule_pkg: shared SHA-256 schedule helpers, K table and FSM state type.
package message_schedule_pkg;
  localparam int ROUNDS = 64;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] rotate_right(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotate_right(x, 7) ^ rotate_right(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotate_right(x, 17) ^ rotate_right(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/message_schedule_if.sv
// message_schedule_if: block-in / word-out handshake bundle; ki exists only with SCHED_KI_EN.
interface message_schedule_if;
  logic blk_valid;
  logic blk_ready;
  logic [15:0][31:0] block_in;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_word;
  logic [5:0] out_round;
  logic out_last;
`ifdef SCHED_KI_EN
  logic [31:0] ki;
  modport master (output blk_valid, block_in, out_ready, input blk_ready, out_valid, out_word, out_round, out_last, ki);
  modport slave (input blk_valid, block_in, out_ready, output blk_ready, out_valid, out_word, out_round, out_last, ki);
`else
  modport master (output blk_valid, block_in, out_ready, input blk_ready, out_valid, out_word, out_round, out_last);
  modport slave (input blk_valid, block_in, out_ready, output blk_ready, out_valid, out_word, out_round, out_last);
`endif
endinterface

// File: rtl/message_schedule_sched_expand.sv
// sched_expand: next schedule word from window taps W[t], W[t+1], W[t+9], W[t+14].
module sched_expand
  import message_schedule_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [31:0] w9_i,
  input  logic [31:0] w14_i,
  output logic [31:0] w_o
);
  assign w_o = sigma1(w14_i) + w9_i + sigma0(w1_i) + w0_i;
endmodule

// File: rtl/message_schedule.sv
// message_schedule: SHA-256 W0..W63 generator over a 16-word sliding window.
// Define SCHED_KI_EN to also emit K[t] alongside each word.
module message_schedule
  import message_schedule_pkg::*;
(
  input logic clk,
  input logic rst,
  message_schedule_if.slave s
);
  state_t state_q, state_d;
  logic [5:0] rnd_q, rnd_d;
  logic [15:0][31:0] win_q, win_d;
  logic [31:0] nxt;
  logic run, last, fire;
  sched_expand u_expand (
    .w0_i (win_q[0]),
    .w1_i (win_q[1]),
    .w9_i (win_q[9]),
    .w14_i(win_q[14]),
    .w_o  (nxt)
  );
  assign run = state_q == RUN;
  assign last = rnd_q == 6'(ROUNDS - 1);
  assign fire = run && s.out_ready;
  // ready on the final handshake lets the next block follow with no bubble
  assign s.blk_ready = !run || (fire && last);
  assign s.out_valid = run;
  assign s.out_word = run ? win_q[0] : '0;
  assign s.out_round = rnd_q;
  assign s.out_last = run && last;
`ifdef SCHED_KI_EN
  assign s.ki = run ? K[rnd_q] : '0;
`endif
  always_comb begin
    state_d = state_q;
    rnd_d = rnd_q;
    win_d = win_q;
    if (s.blk_valid && s.blk_ready) begin
      for (int i = 0; i < 16; i++) win_d[i] = s.block_in[4'(15 - i)];
      rnd_d = '0;
      state_d = RUN;
    end else if (fire) begin
      state_d = last ? IDLE : RUN;
      rnd_d = last ? rnd_q : rnd_q + 6'd1;
      win_d = last ? win_q : {nxt, win_q[15:1]};
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q <= '0;
      win_q <= '0;
    end else begin
      state_q <= state_d;
      rnd_q <= rnd_d;
      win_q <= win_d;
    end
  end
endmodule

// File: tb/tb_message_schedule.sv
// tb_message_schedule: directed checks of the schedule stream, backpressure, chaining and reset.
module tb_message_schedule;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0][31:0] blk_abc, blk_b;
  logic [31:0] mdl [2][64];
  message_schedule_if bus ();
  message_schedule dut (.clk(clk), .rst(rst), .s(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  task automatic build(input int k, input logic [15:0][31:0] b);
    for (int t = 0; t < 16; t++) mdl[k][t] = b[15 - t];
    for (int t = 16; t < 64; t++)
      mdl[k][t] = (ror(mdl[k][t-2], 17) ^ ror(mdl[k][t-2], 19) ^ (mdl[k][t-2] >> 10)) + mdl[k][t-7]
                + (ror(mdl[k][t-15], 7) ^ ror(mdl[k][t-15], 18) ^ (mdl[k][t-15] >> 3)) + mdl[k][t-16];
  endtask

  task automatic chk_word(input string tag, input int k, input int t);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_word"}, bus.out_word, mdl[k][t]);
    chk({tag, "_round"}, 32'(bus.out_round), 32'(t % 64));
    chk({tag, "_last"}, 32'(bus.out_last), 32'(t % 64 == 63));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(bus.blk_ready), 32'd1);
    chk({tag, "_word"}, bus.out_word, 32'd0);
    chk({tag, "_round"}, 32'(bus.out_round), 32'd0);
    chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
`ifdef SCHED_KI_EN
    chk({tag, "_ki"}, bus.ki, 32'd0);
`endif
  endtask

  initial begin
    int hs, cyc;
    logic r;
    blk_abc = '0;
    blk_abc[15] = 32'h61626380;
    blk_abc[0] = 32'h00000018;
    for (int i = 0; i < 16; i++) blk_b[i] = 32'(i) * 32'h9e3779b9 + 32'h00001234;
    build(0, blk_abc);
    build(1, blk_b);
    bus.blk_valid = 1'b0;
    bus.block_in = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    // abc block, no backpressure
    @(negedge clk);
    bus.blk_valid = 1'b1;
    bus.block_in = blk_abc;
    bus.out_ready = 1'b1;
    #1 chk("abc_accept_ready", 32'(bus.blk_ready), 32'd1);
    @(negedge clk);
    bus.blk_valid = 1'b0;
    for (int t = 0; t < 64; t++) begin
      chk_word("abc", 0, t);
      if (t == 0) chk("abc_w0", bus.out_word, 32'h61626380);
      if (t == 15) chk("abc_w15", bus.out_word, 32'h00000018);
      if (t == 16) chk("abc_w16", bus.out_word, 32'h61626380);
      if (t == 17) chk("abc_w17", bus.out_word, 32'h000f0000);
      if (t == 18) chk("abc_w18", bus.out_word, 32'h7da86405);
`ifdef SCHED_KI_EN
      if (t == 0) chk("abc_k0", bus.ki, 32'h428a2f98);
      if (t == 63) chk("abc_k63", bus.ki, 32'hc67178f2);
`endif
      if (t < 63) chk("abc_busy_ready", 32'(bus.blk_ready), 32'd0);
      @(negedge clk);
    end
    chk("abc_done_valid", 32'(bus.out_valid), 32'd0);
    chk("abc_done_ready", 32'(bus.blk_ready), 32'd1);
    // random backpressure on block b
    bus.blk_valid = 1'b1;
    bus.block_in = blk_b;
    @(negedge clk);
    bus.blk_valid = 1'b0;
    hs = 0;
    cyc = 0;
    while (hs < 64 && cyc < 1000) begin
      r = 1'($urandom_range(0, 1));
      bus.out_ready = r;
      chk_word("bp", 1, hs);
      if (r) hs++;
      cyc++;
      @(negedge clk);
    end
    chk("bp_handshakes", 32'(hs), 32'd64);
    chk("bp_done_valid", 32'(bus.out_valid), 32'd0);
    // two chained blocks; blk_valid stays high with a new block during the first
    bus.out_ready = 1'b1;
    bus.blk_valid = 1'b1;
    bus.block_in = blk_abc;
    @(negedge clk);
    bus.block_in = blk_b;
    for (int t = 0; t < 128; t++) begin
      if (t == 64) bus.blk_valid = 1'b0;
      #1;
      chk_word("b2b", t / 64, t % 64);
      chk("b2b_ready", 32'(bus.blk_ready), 32'(t == 63 || t == 127));
      @(negedge clk);
    end
    chk("b2b_done_valid", 32'(bus.out_valid), 32'd0);
    // async reset mid-block
    bus.blk_valid = 1'b1;
    bus.block_in = blk_b;
    @(negedge clk);
    bus.blk_valid = 1'b0;
    for (int t = 0; t < 30; t++) @(negedge clk);
    chk("pre_rst_round", 32'(bus.out_round), 32'd30);
    rst = 1'b1;
    #1 chk_idle("midrst");
    @(negedge clk);
    rst = 1'b0;
    bus.blk_valid = 1'b1;
    bus.block_in = blk_abc;
    @(negedge clk);
    bus.blk_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      chk_word("restart", 0, t);
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
